// File: rtl/sram_tile_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_tile_streamer                                                       |
// | Row-major tile reader for a single-port SRAM with host-write priority.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_tile_streamer #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_W    = 8,
    parameter int DIM_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [DIM_W-1:0]     num_rows,
    input  logic [DIM_W-1:0]     num_cols,
    input  logic [ADDR_W-1:0]    row_stride,
    output logic                 busy,
    output logic                 done,

    input  logic                 wr_req,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 wr_gnt,

    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_data_out,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [DIM_W-1:0]       rows_q;
    logic [DIM_W-1:0]       cols_q;
    logic [ADDR_W-1:0]      stride_q;
    logic [DIM_W-1:0]       row_q;
    logic [DIM_W-1:0]       col_q;
    logic [ADDR_W-1:0]      row_base_q;
    logic [WORD_SIZE-1:0]   out_data_q;
    logic                   out_valid_q;
    logic                   out_last_q;

    logic [DIM_W-1:0]       row_d;
    logic [DIM_W-1:0]       col_d;
    logic [ADDR_W-1:0]      row_base_d;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_last_col;
    logic                   w_last_row;
    logic                   w_last_elem;
    logic                   w_issue;

    assign w_rd_addr   = row_base_q + ADDR_W'(col_q);
    assign w_last_col  = (col_q == cols_q - DIM_W'(1));
    assign w_last_row  = (row_q == rows_q - DIM_W'(1));
    assign w_last_elem = w_last_row && w_last_col;

    // The single output register may be refilled in the same cycle it drains.
    assign w_issue = (state_q == S_STREAM) && !wr_req && (!out_valid_q || out_ready);

    always_comb begin
        col_d      = col_q + DIM_W'(1);
        row_d      = row_q;
        row_base_d = row_base_q;
        if (w_last_col) begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = row_base_q + stride_q;
        end
    end

    always_comb begin
        mem_write   = 1'b0;
        wr_gnt      = 1'b0;
        mem_addr    = '0;
        mem_data_in = wr_data;
        if (wr_req) begin
            mem_write = 1'b1;
            wr_gnt    = 1'b1;
            mem_addr  = wr_addr;
        end else if (state_q == S_STREAM) begin
            mem_addr  = w_rd_addr;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            stride_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rows_q     <= num_rows;
                        cols_q     <= num_cols;
                        stride_q   <= row_stride;
                        row_base_q <= base_addr;
                        row_q      <= '0;
                        col_q      <= '0;
                        if ((num_rows == '0) || (num_cols == '0)) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_issue) begin
                        out_data_q  <= mem_data_out;
                        out_valid_q <= 1'b1;
                        out_last_q  <= w_last_elem;
                        col_q       <= col_d;
                        row_q       <= row_d;
                        row_base_q  <= row_base_d;
                        if (w_last_elem) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_tile_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_tile_streamer                                                    |
// | Directed self-checking bench with a behavioural SRAM (mem[a] = a).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_tile_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] num_rows;
    logic [7:0] num_cols;
    logic [7:0] row_stride;
    logic       busy;
    logic       done;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_gnt;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_write;
    logic [7:0] mem_data_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    logic       mem_init;
    logic [7:0] mem [256];
    logic [7:0] exp_addr [6];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_write) begin
            mem[mem_addr] <= mem_data_in;
        end
    end
    assign mem_data_out = mem[mem_addr];

    sram_tile_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .num_cols     (num_cols),
        .row_stride   (row_stride),
        .busy         (busy),
        .done         (done),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launches a 6-beat tile with out_ready held high and checks every cycle.
    task automatic run_tile(input logic [7:0] base, input logic [7:0] rows,
                            input logic [7:0] cols, input logic [7:0] stride,
                            input string tag);
        start = 1'b1; base_addr = base; num_rows = rows; num_cols = cols;
        row_stride = stride; out_ready = 1'b1;
        tick;
        start = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s addr%0d", tag, i), mem_addr, exp_addr[i]);
            check($sformatf("%s busy%0d", tag, i), busy, 1);
            if (i == 0) begin
                check($sformatf("%s valid%0d", tag, i), out_valid, 0);
            end else begin
                check($sformatf("%s valid%0d", tag, i), out_valid, 1);
                check($sformatf("%s data%0d", tag, i), out_data, exp_addr[i-1]);
                check($sformatf("%s last%0d", tag, i), out_last, 0);
            end
            tick;
            #1;
        end
        check({tag, " drain valid"}, out_valid, 1);
        check({tag, " drain data"}, out_data, exp_addr[5]);
        check({tag, " drain last"}, out_last, 1);
        check({tag, " drain done"}, done, 0);
        tick;
        #1;
        check({tag, " done pulse"}, done, 1);
        check({tag, " done busy"}, busy, 1);
        check({tag, " done valid"}, out_valid, 0);
        tick;
        #1;
        check({tag, " idle done"}, done, 0);
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] beats [6];
        logic [7:0] prev_data;
        logic       prev_last;
        logic       prev_stall;
        logic       seen_done;
        logic [7:0] exp3_addr [8];
        int         n;

        rst_n = 1'b0; mem_init = 1'b1; start = 1'b0;
        base_addr = '0; num_rows = '0; num_cols = '0; row_stride = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
        tick;
        tick;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset valid", out_valid, 0);
        check("reset last", out_last, 0);
        check("reset data", out_data, 0);
        check("reset memaddr", mem_addr, 0);
        check("reset memwrite", mem_write, 0);
        mem_init = 1'b0;
        rst_n = 1'b1;
        tick;

        // Scenario 1: plain 2x3 tile, consecutive issue.
        exp_addr = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16};
        run_tile(8'h10, 8'd2, 8'd3, 8'd4, "t1");

        // Scenario 2: back-pressure pattern 1,0,0 repeating.
        start = 1'b1; base_addr = 8'h10; num_rows = 8'd2; num_cols = 8'd3; row_stride = 8'd4;
        tick;
        start = 1'b0;
        n = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int k = 0; k < 80 && !seen_done; k++) begin
            out_ready = (k % 3 == 0);
            #1;
            if (prev_stall) begin
                check("t2 hold valid", out_valid, 1);
                check("t2 hold data", out_data, prev_data);
                check("t2 hold last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (n < 6) begin
                    check($sformatf("t2 beat%0d", n), out_data, exp_addr[n]);
                    check($sformatf("t2 last%0d", n), out_last, (n == 5));
                end
                n++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) seen_done = 1'b1;
            tick;
        end
        check("t2 beat count", n, 6);
        check("t2 done seen", seen_done, 1);
        out_ready = 1'b1;
        tick;

        // Scenario 3: host write to 0x15 for two cycles preempts the stream.
        exp3_addr = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h15, 8'h15, 8'h16};
        start = 1'b1; base_addr = 8'h10; num_rows = 8'd2; num_cols = 8'd3; row_stride = 8'd4;
        wr_addr = 8'h15; wr_data = 8'hAA;
        tick;
        start = 1'b0;
        n = 0; seen_done = 1'b0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            wr_req = (k == 4) || (k == 5);
            #1;
            if (k < 8) begin
                check($sformatf("t3 addr%0d", k), mem_addr, exp3_addr[k]);
                check($sformatf("t3 mwr%0d", k), mem_write, wr_req);
                check($sformatf("t3 gnt%0d", k), wr_gnt, wr_req);
            end
            if (k == 4) check("t3 wdata", mem_data_in, 8'hAA);
            if (k == 6) check("t3 bubble", out_valid, 0);
            if (out_valid && out_ready) begin
                if (n < 6) beats[n] = out_data;
                n++;
            end
            if (done) seen_done = 1'b1;
            tick;
        end
        wr_req = 1'b0;
        check("t3 beat count", n, 6);
        check("t3 done seen", seen_done, 1);
        check("t3 beat0", beats[0], 8'h10);
        check("t3 beat3", beats[3], 8'h14);
        check("t3 beat4", beats[4], 8'hAA);
        check("t3 beat5", beats[5], 8'h16);
        mem_init = 1'b1;
        tick;
        mem_init = 1'b0;

        // Scenario 4: zero-row tile, and start during busy is ignored.
        start = 1'b1; base_addr = 8'h00; num_rows = 8'd0; num_cols = 8'd5; row_stride = 8'd1;
        tick;
        start = 1'b1; num_rows = 8'd2; num_cols = 8'd3;
        #1;
        check("t4 busy", busy, 1);
        check("t4 done", done, 1);
        check("t4 valid", out_valid, 0);
        tick;
        start = 1'b0;
        #1;
        check("t4 idle busy", busy, 0);
        check("t4 idle done", done, 0);
        tick;
        #1;
        check("t4 ignored busy", busy, 0);
        check("t4 ignored valid", out_valid, 0);

        // Scenario 5: address wrap on both column and row arithmetic.
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h7E, 8'h7F, 8'h80};
        run_tile(8'hFE, 8'd2, 8'd3, 8'h80, "t5");

        // Scenario 6: async reset after three accepted beats.
        exp_addr = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16};
        start = 1'b1; base_addr = 8'h10; num_rows = 8'd2; num_cols = 8'd3; row_stride = 8'd4;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        check("t6 third beat", out_data, 8'h12);
        rst_n = 1'b0;
        #1;
        check("t6 rst valid", out_valid, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst done", done, 0);
        check("t6 rst data", out_data, 0);
        #1;
        rst_n = 1'b1;
        tick;
        run_tile(8'h10, 8'd2, 8'd3, 8'd4, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_tile_streamer.md
Name: sram_tile_streamer

Overview:
Controller for one single-port SRAM (combinational read, write on posedge clk). It streams a rectangular tile of words out of the SRAM in row-major order, using base, stride and row/col counters, to a valid/ready consumer such as a systolic-array feeder. It also shares the SRAM port with a host/DMA write requester, and host writes always win. It sits between the SRAM instance and the GEMM datapath.

Parameters:
WORD_SIZE, 8, data word width in bits
ADDR_W, 8, SRAM address width (memory depth = 2^ADDR_W)
DIM_W, 8, width of the tile row/col count fields

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch a tile read; honoured only in IDLE
base_addr  input  ADDR_W  address of tile element (0,0)
num_rows  input  DIM_W  tile rows
num_cols  input  DIM_W  tile columns
row_stride  input  ADDR_W  address delta between row starts
busy  output  1  high in STREAM, DRAIN and DONE
done  output  1  one-cycle pulse when the tile is complete
wr_req  input  1  host write request
wr_addr  input  ADDR_W  host write address
wr_data  input  WORD_SIZE  host write data
wr_gnt  output  1  host write accepted this cycle (= wr_req)
mem_addr  output  ADDR_W  SRAM address
mem_data_in  output  WORD_SIZE  SRAM write data (= wr_data)
mem_write  output  1  SRAM write enable
mem_data_out  input  WORD_SIZE  SRAM combinational read data
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts the beat
out_data  output  WORD_SIZE  streamed word
out_last  output  1  marks the final beat of the tile

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, out_valid, out_last = 0; out_data = 0; row/col counters and row_base = 0. Config registers are cleared. A reset in the middle of a tile abandons it silently; no done pulse is produced.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: on start, latch base_addr, num_rows, num_cols and row_stride. Set row_base=base_addr, row=0, col=0.
  - Either dimension 0: go to DONE (no beats).
  - Otherwise: go to STREAM.
  - start while busy is ignored.
- Arbitration (every state, combinational):
  - wr_req=1: mem_write=1, mem_addr=wr_addr, wr_gnt=1. No read is issued that cycle.
  - Otherwise: mem_write=0, and mem_addr = current read address in STREAM, else 0.
- STREAM: issue = !wr_req && (!out_valid || out_ready).
  - On issue: mem_addr = row_base + col (mod 2^ADDR_W). At the clock edge, out_data <= mem_data_out, out_valid <= 1, out_last <= (row==num_rows-1 && col==num_cols-1).
  - Read-to-output latency: 1 cycle.
  - Counter advance: if col==num_cols-1, then col=0, row++, row_base += row_stride (mod 2^ADDR_W). Else col++.
  - After issuing the last element, go to DRAIN.
  - No issue and out_valid && out_ready: out_valid <= 0.
- DRAIN: hold out_data/out_last until out_ready. On acceptance: out_valid <= 0, out_last <= 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- Handshake: out_data and out_last stay stable while out_valid && !out_ready. There is one beat of storage; throughput is 1 word/cycle with out_ready=1 and no writes.
- Coherency: a write granted in cycle N is visible to reads issued in cycle N+1 or later.
- Address arithmetic wraps modulo 2^ADDR_W; there is no error on wrap.
- Host writes during a tile may modify tile data not yet read. That is legal; the streamed value is whatever the SRAM holds at issue time.

Test Plan:
1. base=0x10, rows=2, cols=3, stride=4, out_ready=1, SRAM[a]=a → issued addrs 0x10,0x11,0x12,0x14,0x15,0x16 on consecutive cycles. out_data follows the same sequence 1 cycle later. out_last only on 0x16. done pulses 2 cycles after the last issue.
2. Same tile with out_ready toggling 1,0,0,1,… → no beat lost or duplicated, and out_data is held stable while stalled. Exactly 6 accepted beats.
3. During scenario 1, wr_req=1 for 2 cycles at addr 0x15, data 0xAA, before 0x15 is read → stream stalls 2 cycles, wr_gnt=1 and mem_write=1 those cycles. The beat for 0x15 is 0xAA.
4. start with rows=0, cols=5 → no out_valid, busy=1 for 1 cycle, done pulses the cycle after start. start pulsed during busy → ignored.
5. base=0xFE, rows=2, cols=3, stride=0x80 → addrs 0xFE,0xFF,0x00,0x7E,0x7F,0x80.
6. rst_n low after 3 beats of scenario 1 → out_valid=0, busy=0 and done=0 immediately (async). A new start then streams from 0x10 cleanly.
